// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU/branch/jump/load-store resolution plus an optional
// 32-cycle restoring divider (DIV/DIVU/REM/REMU), enabled by defining RV32M_DIV_EN.
`ifndef EX_STAGE_BUS_DEFS
`define EX_STAGE_BUS_DEFS
`define AluSelBus  3:0
`define AluOpBus   7:0
`define RegBus     31:0
`define RegAddrBus 4:0
`define MemAddrBus 31:0
`endif

module ex_stage (
  input  logic               clock,
  input  logic               reset,
  input  logic [`AluSelBus]  alusel_i,
  input  logic [`AluOpBus]   aluop_i,
  input  logic [`RegBus]     op1_i,
  input  logic [`RegBus]     op2_i,
  input  logic [`RegBus]     link_addr_i,
  input  logic               write_i,
  input  logic [`RegAddrBus] regw_addr_i,
  input  logic [`RegBus]     mem_offset_i,
  input  logic [`MemAddrBus] br_addr_i,
  input  logic [`MemAddrBus] br_offset_i,
  output logic               write_o,
  output logic [`RegAddrBus] regw_addr_o,
  output logic [`RegBus]     regw_data_o,
  output logic [`AluOpBus]   aluop_o,
  output logic [`MemAddrBus] mem_addr_o,
  output logic [`RegBus]     mem_data_o,
  output logic               br_o,
  output logic [`MemAddrBus] br_target_o,
  output logic               stall_req_o
);
  localparam logic [3:0] SEL_LOGIC = 4'd1, SEL_SHIFT = 4'd2, SEL_ARITH = 4'd3, SEL_CMP = 4'd4,
                         SEL_JUMP  = 4'd5, SEL_BRANCH = 4'd6, SEL_DIV = 4'd8;
  localparam logic [7:0] OP_AND = 8'h01, OP_OR = 8'h02, OP_XOR = 8'h03, OP_SLL = 8'h04,
                         OP_SRL = 8'h05, OP_SRA = 8'h06, OP_ADD = 8'h07, OP_SUB = 8'h08,
                         OP_SLT = 8'h09, OP_SLTU = 8'h0A, OP_BEQ = 8'h0D, OP_BNE = 8'h0E,
                         OP_BLT = 8'h0F, OP_BGE = 8'h10, OP_BLTU = 8'h11, OP_BGEU = 8'h12,
                         OP_DIV = 8'h1B, OP_DIVU = 8'h1C, OP_REM = 8'h1D, OP_REMU = 8'h1E;

  logic [31:0] alu_res;
  logic        alu_br, lt_s, lt_u, is_div;

  assign lt_s   = $signed(op1_i) < $signed(op2_i);
  assign lt_u   = op1_i < op2_i;
  assign is_div = (alusel_i == SEL_DIV);

  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    case (alusel_i)
      SEL_LOGIC: case (aluop_i)
        OP_AND:  alu_res = op1_i & op2_i;
        OP_OR:   alu_res = op1_i | op2_i;
        OP_XOR:  alu_res = op1_i ^ op2_i;
        default: alu_res = '0;
      endcase
      SEL_SHIFT: case (aluop_i)
        OP_SLL:  alu_res = op1_i << op2_i[4:0];
        OP_SRL:  alu_res = op1_i >> op2_i[4:0];
        OP_SRA:  alu_res = $unsigned($signed(op1_i) >>> op2_i[4:0]);
        default: alu_res = '0;
      endcase
      SEL_ARITH: case (aluop_i)
        OP_ADD:  alu_res = op1_i + op2_i;
        OP_SUB:  alu_res = op1_i - op2_i;
        default: alu_res = '0;
      endcase
      SEL_CMP: case (aluop_i)
        OP_SLT:  alu_res = {31'b0, lt_s};
        OP_SLTU: alu_res = {31'b0, lt_u};
        default: alu_res = '0;
      endcase
      SEL_JUMP: begin
        alu_res = link_addr_i;
        alu_br  = 1'b1;
      end
      SEL_BRANCH: case (aluop_i)
        OP_BEQ:  alu_br = (op1_i == op2_i);
        OP_BNE:  alu_br = (op1_i != op2_i);
        OP_BLT:  alu_br = lt_s;
        OP_BGE:  alu_br = ~lt_s;
        OP_BLTU: alu_br = lt_u;
        OP_BGEU: alu_br = ~lt_u;
        default: alu_br = 1'b0;
      endcase
      default: alu_res = '0;
    endcase
  end

`ifdef RV32M_DIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;
  div_state_e  state, state_nx;
  logic [5:0]  cnt;
  logic [31:0] quo_r, rem_r, dvs_r, abs1, abs2, div_res;
  logic [32:0] rem_sh, rem_diff;
  logic        neg_q_r, neg_r_r, signed_op, quo_op, s1, s2, div_zero, div_ovf, step_ok;
  logic        div_stall, div_done;

  assign signed_op = (aluop_i == OP_DIV) || (aluop_i == OP_REM);
  assign quo_op    = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign s1        = signed_op & op1_i[31];
  assign s2        = signed_op & op2_i[31];
  assign abs1      = s1 ? -op1_i : op1_i;
  assign abs2      = s2 ? -op2_i : op2_i;
  assign div_zero  = (op2_i == '0);
  assign div_ovf   = signed_op && (op1_i == 32'h8000_0000) && (op2_i == 32'hFFFF_FFFF);
  // Partial remainder stays below the divisor, so the shifted value fits in 33 bits.
  assign rem_sh    = {rem_r, quo_r[31]};
  assign rem_diff  = rem_sh - {1'b0, dvs_r};
  assign step_ok   = ~rem_diff[32];
  assign div_res   = quo_op ? (neg_q_r ? -quo_r : quo_r) : (neg_r_r ? -rem_r : rem_r);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    div_stall = 1'b0;
    div_done  = 1'b0;
    case (state)
      IDLE: if (is_div) begin
        div_stall = 1'b1;
        state_nx  = (div_zero || div_ovf) ? DONE : BUSY;
      end
      BUSY: begin
        div_stall = 1'b1;
        if (cnt == 6'd31) state_nx = DONE;
      end
      DONE: begin
        div_done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      quo_r   <= '0;
      rem_r   <= '0;
      dvs_r   <= '0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (is_div) begin
          cnt <= '0;
          // Special cases preload the final result and bypass sign fix-up.
          if (div_zero) begin
            quo_r <= 32'hFFFF_FFFF; rem_r <= op1_i; neg_q_r <= 1'b0; neg_r_r <= 1'b0;
          end else if (div_ovf) begin
            quo_r <= 32'h8000_0000; rem_r <= '0;    neg_q_r <= 1'b0; neg_r_r <= 1'b0;
          end else begin
            quo_r <= abs1; rem_r <= '0; dvs_r <= abs2; neg_q_r <= s1 ^ s2; neg_r_r <= s1;
          end
        end
        BUSY: begin
          quo_r <= {quo_r[30:0], step_ok};
          rem_r <= step_ok ? rem_diff[31:0] : rem_sh[31:0];
          cnt   <= cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end
`else
  // Without the divider the clock has no other load.
  logic unused_clock;
  assign unused_clock = clock;
`endif

  always_comb begin
    write_o     = 1'b0;
    regw_addr_o = '0;
    regw_data_o = '0;
    aluop_o     = '0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    br_o        = 1'b0;
    br_target_o = '0;
    stall_req_o = 1'b0;
    if (!reset) begin
      regw_addr_o = regw_addr_i;
      aluop_o     = aluop_i;
      mem_addr_o  = op1_i + mem_offset_i;
      mem_data_o  = op2_i;
      br_target_o = br_addr_i + br_offset_i;
      if (is_div) begin
`ifdef RV32M_DIV_EN
        stall_req_o = div_stall;
        if (div_done) begin
          regw_data_o = div_res;
          write_o     = write_i;
        end
`endif
      end else begin
        regw_data_o = alu_res;
        write_o     = write_i;
        br_o        = alu_br;
      end
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage; divide expectations follow the RV32M_DIV_EN build.
module tb_ex_stage;
  localparam logic [3:0] SEL_NOP = 4'd0, SEL_LOGIC = 4'd1, SEL_SHIFT = 4'd2, SEL_ARITH = 4'd3,
                         SEL_CMP = 4'd4, SEL_JUMP = 4'd5, SEL_BRANCH = 4'd6, SEL_LDST = 4'd7,
                         SEL_DIV = 4'd8;
  localparam logic [7:0] OP_AND = 8'h01, OP_OR = 8'h02, OP_XOR = 8'h03, OP_SLL = 8'h04,
                         OP_SRL = 8'h05, OP_SRA = 8'h06, OP_ADD = 8'h07, OP_SUB = 8'h08,
                         OP_SLT = 8'h09, OP_SLTU = 8'h0A, OP_JAL = 8'h0B, OP_BEQ = 8'h0D,
                         OP_BNE = 8'h0E, OP_BLT = 8'h0F, OP_BGEU = 8'h12, OP_LW = 8'h15,
                         OP_DIV = 8'h1B, OP_DIVU = 8'h1C, OP_REM = 8'h1D, OP_REMU = 8'h1E;
  localparam logic [31:0] LINK = 32'h0000_1004;

  logic        clock = 1'b0, reset = 1'b1;
  logic [3:0]  alusel_i = '0;
  logic [7:0]  aluop_i = '0;
  logic [31:0] op1_i = '0, op2_i = '0, link_addr_i = LINK, mem_offset_i = 32'h10;
  logic [31:0] br_addr_i = 32'h2000, br_offset_i = 32'h40;
  logic        write_i = 1'b1;
  logic [4:0]  regw_addr_i = 5'd7;
  logic        write_o, br_o, stall_req_o;
  logic [4:0]  regw_addr_o;
  logic [31:0] regw_data_o, mem_addr_o, mem_data_o, br_target_o;
  logic [7:0]  aluop_o;

  ex_stage dut (
    .clock(clock), .reset(reset), .alusel_i(alusel_i), .aluop_i(aluop_i),
    .op1_i(op1_i), .op2_i(op2_i), .link_addr_i(link_addr_i), .write_i(write_i),
    .regw_addr_i(regw_addr_i), .mem_offset_i(mem_offset_i), .br_addr_i(br_addr_i),
    .br_offset_i(br_offset_i), .write_o(write_o), .regw_addr_o(regw_addr_o),
    .regw_data_o(regw_data_o), .aluop_o(aluop_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .br_o(br_o), .br_target_o(br_target_o),
    .stall_req_o(stall_req_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        wr;
    logic        br;
    int          stalls;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] div_model(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : $unsigned($signed(a) / $signed(b));
      OP_REM:  return (b == 0) ? a : ovf ? 32'h0 : $unsigned($signed(a) % $signed(b));
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drive one instruction and queue what the stage must eventually produce.
  task automatic issue(input string tag, input logic [3:0] sel, input logic [7:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ed, input logic eb, input int es, input logic ew);
    exp_t e;
    alusel_i = sel; aluop_i = op; op1_i = a; op2_i = b;
    e.tag = tag; e.data = ed; e.br = eb; e.stalls = es; e.wr = ew;
    sb.push_back(e);
  endtask

  task automatic collect();
    exp_t e;
    int   n;
    n = 0;
    @(negedge clock);
    while (stall_req_o === 1'b1 && n < 100) begin
      chk("stall_write", {31'b0, write_o}, 32'h0);
      n++;
      @(negedge clock);
    end
    e = sb.pop_front();
    chk({e.tag, ":stalls"}, n, e.stalls);
    chk({e.tag, ":data"}, regw_data_o, e.data);
    chk({e.tag, ":write"}, {31'b0, write_o}, {31'b0, e.wr});
    chk({e.tag, ":br"}, {31'b0, br_o}, {31'b0, e.br});
    @(posedge clock); #1;
  endtask

  task automatic run_alu(input string tag, input logic [3:0] sel, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ed, input logic eb);
    issue(tag, sel, op, a, b, ed, eb, 0, 1'b1);
    collect();
  endtask

  task automatic run_div(input string tag, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
`ifdef RV32M_DIV_EN
    issue(tag, SEL_DIV, op, a, b, div_model(op, a, b), 1'b0, (b == 0 || ovf) ? 1 : 33, 1'b1);
`else
    issue(tag, SEL_DIV, op, a, b, ovf ? 32'h0 : 32'h0, 1'b0, 0, 1'b0);
`endif
    collect();
  endtask

  initial begin
    alusel_i = SEL_ARITH; aluop_i = OP_ADD; op1_i = 32'h1234; op2_i = 32'h1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_data", regw_data_o, 32'h0);
    chk("rst_ctl", {27'b0, write_o, br_o, stall_req_o, 2'b0}, 32'h0);
    chk("rst_addr", mem_addr_o | br_target_o | mem_data_o, 32'h0);
    chk("rst_misc", {19'b0, aluop_o, regw_addr_o}, 32'h0);
    @(posedge clock); #1 reset = 1'b0;

    run_alu("add_wrap", SEL_ARITH, OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    run_alu("sub",  SEL_ARITH, OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_alu("and",  SEL_LOGIC, OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0);
    run_alu("or",   SEL_LOGIC, OP_OR,  32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b0);
    run_alu("xor",  SEL_LOGIC, OP_XOR, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b0);
    run_alu("sll5b", SEL_SHIFT, OP_SLL, 32'h0000_0003, 32'd33, 32'h0000_0006, 1'b0);
    run_alu("srl",  SEL_SHIFT, OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0);
    run_alu("sra",  SEL_SHIFT, OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    run_alu("slt",  SEL_CMP, OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    run_alu("sltu", SEL_CMP, OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    run_alu("jal",  SEL_JUMP, OP_JAL, 32'h0, 32'h0, LINK, 1'b1);
    run_alu("beq_t", SEL_BRANCH, OP_BEQ, 32'd9, 32'd9, 32'h0, 1'b1);
    run_alu("bne_nt", SEL_BRANCH, OP_BNE, 32'd9, 32'd9, 32'h0, 1'b0);
    run_alu("blt_t", SEL_BRANCH, OP_BLT, 32'hFFFF_FFF0, 32'd2, 32'h0, 1'b1);
    run_alu("bgeu_nt", SEL_BRANCH, OP_BGEU, 32'd1, 32'hFFFF_FFF0, 32'h0, 1'b0);

    alusel_i = SEL_LDST; aluop_i = OP_LW; op1_i = 32'h100; op2_i = 32'hCAFE;
    @(negedge clock);
    chk("ld_addr", mem_addr_o, 32'h110);
    chk("st_data", mem_data_o, 32'hCAFE);
    chk("br_target", br_target_o, 32'h2040);
    chk("aluop_pass", {24'b0, aluop_o}, {24'b0, OP_LW});
    @(posedge clock); #1;

    run_div("div_neg", OP_DIV, 32'd100, 32'hFFFF_FFF9);
    run_div("rem_neg", OP_REM, 32'hFFFF_FF9C, 32'd7);
    run_div("divu_z", OP_DIVU, 32'd5, 32'd0);
    run_div("remu_z", OP_REMU, 32'd5, 32'd0);
    run_div("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] op;
      op = OP_DIV + 8'(i % 4);
      run_div($sformatf("rnd%0d", i), op, $urandom, $urandom_range(1, 32'h7FFF_FFFF) >> (i * 4));
    end

    // Abort a divide mid-flight with reset.
    alusel_i = SEL_DIV; aluop_i = OP_DIVU; op1_i = 32'd100; op2_i = 32'd7;
    repeat (11) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("abort_data", regw_data_o, 32'h0);
    chk("abort_ctl", {29'b0, write_o, br_o, stall_req_o}, 32'h0);
    @(posedge clock); #1 reset = 1'b0;
    run_div("divu_after_rst", OP_DIVU, 32'd9, 32'd3);

    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
